operand_packer: RTL

Upstream feeder for the divide-multiply pipeline's input FIFO. It accepts a byte stream over a valid/ready handshake and pairs each dividend byte with the divisor byte that follows it. Each pair is packed as {dividend, divisor} into the 16-bit FIFO write word. The write is issued only when the FIFO reports enough free space through its left-count signal, and pairs with a zero divisor are rejected before they reach the divider.

---
 rtl/operand_packer_pkg.sv | 20 ++
 rtl/operand_packer.sv | 70 +++++++
 2 files changed

// File: rtl/operand_packer_pkg.sv
// Shared definitions for the operand packer and the downstream FIFO / divider stages.
// Holds the packer state encoding and the operand/word widths.
package operand_packer_pkg;

  localparam int unsigned OPW   = 8;
  localparam int unsigned WORDW = 16;

  typedef enum logic [1:0] {
    StHi   = 2'd0,
    StLo   = 2'd1,
    StWait = 2'd2
  } state_e;

  // Dividend occupies the upper byte of the FIFO word.
  function automatic logic [WORDW-1:0] pack_pair(input logic [OPW-1:0] dividend,
                                                 input logic [OPW-1:0] divisor);
    return {dividend, divisor};
  endfunction

endpackage

// File: rtl/operand_packer.sv
// Pairs a dividend byte with the following divisor byte and writes {dividend, divisor}
// into the divider input FIFO once it has room; zero divisors are dropped with an error pulse.
module operand_packer
  import operand_packer_pkg::*;
#(
  parameter logic [4:0] LEFT_MIN = 5'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             byte_valid,
  input  logic [OPW-1:0]   byte_data,
  output logic             byte_ready,
  input  logic [4:0]       left_sig,
  output logic             write_req,
  output logic [WORDW-1:0] fifo_write_data,
  output logic             div_zero_err,
  output logic [7:0]       pair_count
);

  state_e         state_q;
  logic [OPW-1:0] dividend_q;
  logic [OPW-1:0] divisor_q;

  // Gated by rst_n so the source sees no ready while reset is held.
  assign byte_ready = rst_n & (state_q != StWait);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StHi;
      dividend_q      <= '0;
      divisor_q       <= '0;
      write_req       <= 1'b0;
      fifo_write_data <= '0;
      div_zero_err    <= 1'b0;
      pair_count      <= '0;
    end else begin
      write_req    <= 1'b0;
      div_zero_err <= 1'b0;
      unique case (state_q)
        StHi: begin
          if (byte_valid) begin
            dividend_q <= byte_data;
            state_q    <= StLo;
          end
        end
        StLo: begin
          if (byte_valid) begin
            if (byte_data == '0) begin
              div_zero_err <= 1'b1;
              state_q      <= StHi;
            end else begin
              divisor_q <= byte_data;
              state_q   <= StWait;
            end
          end
        end
        StWait: begin
          if (left_sig >= LEFT_MIN) begin
            write_req       <= 1'b1;
            fifo_write_data <= pack_pair(dividend_q, divisor_q);
            pair_count      <= pair_count + 8'd1;
            state_q         <= StHi;
          end
        end
        default: state_q <= StHi;
      endcase
    end
  end

endmodule
